// File: rtl/ppu_pixel_output.sv
// rtl/ppu_pixel_output.sv - PPU final stage: dot/line timing, priority mux, palette RAM, status flags.
// Optional left-column clipping is compiled in with `define PPU_LEFT_CLIP_EN.
module ppu_pixel_output #(
  parameter int DOTS_PER_LINE   = 341,
  parameter int LINES_PER_FRAME = 262,
  parameter int VBLANK_LINE     = 241,
  parameter int PRERENDER_LINE  = 261
) (
  input  logic       ppu_clk,
  input  logic       reset,
  input  logic       bg_en,
  input  logic       spr_en,
  input  logic       show_bg_left,
  input  logic       show_spr_left,
  input  logic       grayscale,
  input  logic       nmi_en,
  input  logic       status_rd,
  input  logic [3:0] bg_pixel,
  input  logic [3:0] spr_pixel,
  input  logic       spr_behind,
  input  logic       spr_zero,
  input  logic       pal_wr,
  input  logic [4:0] pal_addr,
  input  logic [7:0] pal_wdata,
  output logic [7:0] pal_rdata,
  output logic [7:0] ppu_pixel,
  output logic [8:0] ppu_x,
  output logic [8:0] ppu_y,
  output logic       vblank,
  output logic       nmi,
  output logic       spr0_hit,
  output logic       odd_frame
);

  // Rendered lines end one line before vblank starts (240 for the stock timing).
  localparam int VISIBLE_LINES = VBLANK_LINE - 1;

  logic [8:0] dot;
  logic [8:0] line;
  logic [5:0] pal_ram [0:31];

  logic       visible;
  logic [8:0] x;
  logic       bg_left_ok;
  logic       spr_left_ok;
  logic       bg_opaque;
  logic       spr_opaque;
  logic [4:0] render_addr;
  logic [5:0] colour;
  logic       skip_dot;
  logic       at_vbl_set;
  logic       at_pre_clear;
  logic [1:0] unused_wdata;

  function automatic logic [4:0] pal_mirror(input logic [4:0] a);
    return (a[4] && (a[1:0] == 2'b00)) ? {1'b0, a[3:0]} : a;
  endfunction

  assign unused_wdata = pal_wdata[7:6];

`ifdef PPU_LEFT_CLIP_EN
  assign bg_left_ok  = (x >= 9'd8) || show_bg_left;
  assign spr_left_ok = (x >= 9'd8) || show_spr_left;
`else
  logic unused_left;
  assign unused_left = show_bg_left ^ show_spr_left;
  assign bg_left_ok  = 1'b1;
  assign spr_left_ok = 1'b1;
`endif

  always_comb begin
    visible     = (line < 9'(VISIBLE_LINES)) && (dot >= 9'd1) && (dot <= 9'd256);
    x           = dot - 9'd1;
    bg_opaque   = (bg_pixel[1:0] != 2'b00) && bg_en && bg_left_ok;
    spr_opaque  = (spr_pixel[1:0] != 2'b00) && spr_en && spr_left_ok;
    render_addr = 5'h00;
    if (spr_opaque && (!bg_opaque || !spr_behind))
      render_addr = {1'b1, spr_pixel};
    else if (bg_opaque)
      render_addr = {1'b0, bg_pixel};
    colour       = pal_ram[pal_mirror(render_addr)] & (grayscale ? 6'h30 : 6'h3F);
    skip_dot     = (bg_en || spr_en) && odd_frame &&
                   (line == 9'(PRERENDER_LINE)) && (dot == 9'(DOTS_PER_LINE - 2));
    at_vbl_set   = (line == 9'(VBLANK_LINE)) && (dot == 9'd1);
    at_pre_clear = (line == 9'(PRERENDER_LINE)) && (dot == 9'd1);
  end

  assign pal_rdata = {2'b00, pal_ram[pal_mirror(pal_addr)]};
  assign nmi       = vblank & nmi_en;

  // Palette contents survive reset; render reads above see the pre-write value.
  always_ff @(posedge ppu_clk) begin
    if (pal_wr)
      pal_ram[pal_mirror(pal_addr)] <= pal_wdata[5:0];
  end

  always_ff @(posedge ppu_clk) begin
    if (reset) begin
      dot       <= 9'd0;
      line      <= 9'd0;
      odd_frame <= 1'b0;
    end else if (skip_dot || (dot == 9'(DOTS_PER_LINE - 1))) begin
      dot <= 9'd0;
      if (skip_dot || (line == 9'(LINES_PER_FRAME - 1))) begin
        line      <= 9'd0;
        odd_frame <= ~odd_frame;
      end else begin
        line <= line + 9'd1;
      end
    end else begin
      dot <= dot + 9'd1;
    end
  end

  always_ff @(posedge ppu_clk) begin
    if (reset) begin
      ppu_pixel <= 8'h00;
      ppu_x     <= 9'h1FF;
      ppu_y     <= 9'h1FF;
      vblank    <= 1'b0;
      spr0_hit  <= 1'b0;
    end else begin
      ppu_pixel <= {2'b00, colour};
      ppu_x     <= visible ? x : 9'h1FF;
      ppu_y     <= visible ? line : 9'h1FF;
      // A status read coinciding with the set point wins, so vblank is lost for that frame.
      if (status_rd || at_pre_clear)
        vblank <= 1'b0;
      else if (at_vbl_set)
        vblank <= 1'b1;
      if (at_pre_clear)
        spr0_hit <= 1'b0;
      else if (spr_zero && bg_opaque && spr_opaque && visible && (x != 9'd255))
        spr0_hit <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ppu_pixel_output.sv
// tb/tb_ppu_pixel_output.sv - self-checking bench for ppu_pixel_output against a frame-position model.
// A shortened frame (12 lines) keeps the run short; dot timing per line is the stock 341.
module tb_ppu_pixel_output;

  localparam int DPL = 341;
  localparam int LPF = 12;
  localparam int VBL = 8;
  localparam int PRE = 11;
  localparam int FL  = DPL * LPF;
`ifdef PPU_LEFT_CLIP_EN
  localparam bit CLIP = 1'b1;
`else
  localparam bit CLIP = 1'b0;
`endif

  logic       ppu_clk = 1'b0;
  logic       reset, bg_en, spr_en, show_bg_left, show_spr_left, grayscale, nmi_en, status_rd;
  logic [3:0] bg_pixel, spr_pixel;
  logic       spr_behind, spr_zero, pal_wr;
  logic [4:0] pal_addr;
  logic [7:0] pal_wdata, pal_rdata, ppu_pixel;
  logic [8:0] ppu_x, ppu_y;
  logic       vblank, nmi, spr0_hit, odd_frame;

  ppu_pixel_output #(
    .DOTS_PER_LINE(DPL), .LINES_PER_FRAME(LPF), .VBLANK_LINE(VBL), .PRERENDER_LINE(PRE)
  ) dut (
    .ppu_clk(ppu_clk), .reset(reset), .bg_en(bg_en), .spr_en(spr_en),
    .show_bg_left(show_bg_left), .show_spr_left(show_spr_left), .grayscale(grayscale),
    .nmi_en(nmi_en), .status_rd(status_rd), .bg_pixel(bg_pixel), .spr_pixel(spr_pixel),
    .spr_behind(spr_behind), .spr_zero(spr_zero), .pal_wr(pal_wr), .pal_addr(pal_addr),
    .pal_wdata(pal_wdata), .pal_rdata(pal_rdata), .ppu_pixel(ppu_pixel), .ppu_x(ppu_x),
    .ppu_y(ppu_y), .vblank(vblank), .nmi(nmi), .spr0_hit(spr0_hit), .odd_frame(odd_frame)
  );

  always #5 ppu_clk = ~ppu_clk;

  int total = 0;
  int bad   = 0;

  // Reference model: position inside the frame as a single cycle count.
  int       pos = 0;
  bit       m_odd, m_vb, m_hit;
  int       mp [32];
  int       e_pix, e_x, e_y;

  function automatic int mir(input int a);
    if (a >= 16 && a % 4 == 0) return a - 16;
    return a;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    int ln, dt, x, a;
    bit vis, bo, so;
    ln  = pos / DPL;
    dt  = pos % DPL;
    x   = dt - 1;
    vis = (ln < VBL - 1) && (dt >= 1) && (dt <= 256);
    bo  = (bg_pixel[1:0] != 0) && bg_en && (x >= 8 || show_bg_left || !CLIP);
    so  = (spr_pixel[1:0] != 0) && spr_en && (x >= 8 || show_spr_left || !CLIP);
    if (so && (!bo || !spr_behind)) a = 16 + int'(spr_pixel);
    else if (bo) a = int'(bg_pixel);
    else a = 0;
    if (reset) begin
      e_pix = 0; e_x = 'h1FF; e_y = 'h1FF;
      m_vb = 0; m_hit = 0; m_odd = 0; pos = 0;
    end else begin
      e_pix = mp[mir(a)] & (grayscale ? 'h30 : 'h3F);
      e_x   = vis ? x : 'h1FF;
      e_y   = vis ? ln : 'h1FF;
      if (status_rd) m_vb = 0;
      else if (ln == VBL && dt == 1) m_vb = 1;
      else if (ln == PRE && dt == 1) m_vb = 0;
      if (ln == PRE && dt == 1) m_hit = 0;
      else if (spr_zero && bo && so && vis && x != 255) m_hit = 1;
      pos++;
      if (pos == FL || (pos == FL - 1 && m_odd && (bg_en || spr_en))) begin
        pos = 0;
        m_odd = !m_odd;
      end
    end
    if (pal_wr) mp[mir(int'(pal_addr))] = int'(pal_wdata[5:0]);
    @(posedge ppu_clk);
    #1;
    chk("ppu_x", ppu_x, e_x);
    chk("ppu_y", ppu_y, e_y);
    if (reset || e_x != 'h1FF) chk("ppu_pixel", ppu_pixel, e_pix);
    chk("vblank", vblank, m_vb);
    chk("nmi", nmi, m_vb & nmi_en);
    chk("spr0_hit", spr0_hit, m_hit);
    chk("odd_frame", odd_frame, m_odd);
    chk("pal_rdata", pal_rdata, mp[mir(int'(pal_addr))]);
  endtask

  task automatic rnd_pix();
    bg_pixel   = 4'($urandom);
    spr_pixel  = 4'($urandom);
    spr_behind = 1'($urandom);
    spr_zero   = 1'($urandom);
  endtask

  task automatic run_to(input int ln, input int dt, input bit rnd);
    int n;
    n = 0;
    while (pos != ln * DPL + dt && n < 3 * FL) begin
      if (rnd) rnd_pix();
      tick();
      n++;
    end
    if (n >= 3 * FL) begin
      total++; bad++;
      $error("FAIL run_to observed=%0d expected=%0d", pos, ln * DPL + dt);
    end
  endtask

  task automatic wait_origin(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!(ppu_x == 9'd0 && ppu_y == 9'd0) && n < 3 * FL);
  endtask

  initial begin
    int n, par;
    reset = 1; bg_en = 0; spr_en = 0; show_bg_left = 1; show_spr_left = 1;
    grayscale = 0; nmi_en = 0; status_rd = 0; bg_pixel = 0; spr_pixel = 0;
    spr_behind = 0; spr_zero = 0; pal_wr = 0; pal_addr = 0; pal_wdata = 0;
    for (int i = 0; i < 32; i++) mp[i] = 0;

    // Reset held while the palette is loaded with random contents.
    for (int i = 0; i < 32; i++) begin
      pal_wr = 1; pal_addr = 5'(i); pal_wdata = 8'($urandom);
      tick();
    end
    pal_wr = 0;
    chk("rst_pixel", ppu_pixel, 8'h00);
    chk("rst_xy", {ppu_x, ppu_y}, 18'h3FFFF);

    // One full even frame with rendering off: returns to origin with odd_frame set.
    reset = 0;
    for (int i = 0; i < FL; i++) begin
      rnd_pix();
      show_bg_left = 1'($urandom); grayscale = 1'($urandom);
      tick();
    end
    chk("frame1_odd", odd_frame, 1'b1);
    grayscale = 0; show_bg_left = 1; bg_pixel = 0; spr_pixel = 0; spr_zero = 0;

    pal_wr = 1; pal_addr = 5'h00; pal_wdata = 8'h0F; tick();
    pal_addr = 5'h05; pal_wdata = 8'h16; tick();
    pal_wr = 0;
    run_to(0, 1, 0);
    bg_en = 1; bg_pixel = 4'h5; tick();
    chk("bg_pix", ppu_pixel, 8'h16);
    chk("first_x", ppu_x, 9'd0);
    chk("first_y", ppu_y, 9'd0);
    bg_pixel = 4'h4; tick();
    chk("backdrop", ppu_pixel, 8'h0F);

    pal_wr = 1; pal_addr = 5'h10; pal_wdata = 8'h21; tick();
    pal_wr = 0;
    chk("mirror_rd10", pal_rdata, 8'h21);
    pal_addr = 5'h00; #1;
    chk("mirror_rd00", pal_rdata, 8'h21);
    grayscale = 1; bg_pixel = 4'h5; tick();
    chk("grayscale", ppu_pixel, 8'h10);
    grayscale = 0;

    pal_wr = 1; pal_addr = 5'h01; pal_wdata = 8'h2A; tick();
    pal_addr = 5'h12; pal_wdata = 8'h35; tick();
    pal_wr = 0;
    spr_en = 1; bg_pixel = 4'h1; spr_pixel = 4'h2; spr_behind = 1; tick();
    chk("spr_behind", ppu_pixel, 8'h2A);
    spr_behind = 0; tick();
    chk("spr_front", ppu_pixel, 8'h35);
    run_to(0, 256, 0);
    spr_zero = 1; tick();
    chk("hit_x255", spr0_hit, 1'b0);
    spr_zero = 0;
    run_to(1, 101, 0);
    spr_zero = 1; tick();
    chk("hit_x100", spr0_hit, 1'b1);
    spr_zero = 0;

    nmi_en = 1;
    run_to(VBL, 1, 1);
    tick();
    chk("vbl_set", vblank, 1'b1);
    chk("nmi_set", nmi, 1'b1);
    nmi_en = 0; #1;
    chk("nmi_off", nmi, 1'b0);
    nmi_en = 1; #1;
    chk("nmi_on", nmi, 1'b1);
    run_to(VBL, 5, 1);
    status_rd = 1; tick(); status_rd = 0;
    chk("vbl_rd_clear", vblank, 1'b0);
    run_to(VBL, 1, 1);
    status_rd = 1; tick(); status_rd = 0;
    chk("vbl_suppress", vblank, 1'b0);
    run_to(VBL + 2, 0, 1);
    chk("vbl_suppress_hold", vblank, 1'b0);

    // Frame length measured from DUT output origin to the next one.
    spr_en = 0; bg_pixel = 0; spr_pixel = 0;
    wait_origin(n);
    for (int k = 0; k < 2; k++) begin
      par = m_odd;
      wait_origin(n);
      chk(par ? "odd_frame_len" : "even_frame_len", n, par ? FL - 1 : FL);
    end

    show_bg_left = 0;
    run_to(0, 4, 0);
    bg_pixel = 4'h5; tick();
    chk("left_clip", ppu_pixel, CLIP ? 8'h21 : 8'h16);
    show_bg_left = 1;

    // Fully random frame including palette traffic and status reads.
    for (int i = 0; i < FL; i++) begin
      rnd_pix();
      bg_en = 1'($urandom); spr_en = 1'($urandom);
      show_bg_left = 1'($urandom); show_spr_left = 1'($urandom);
      grayscale = 1'($urandom); nmi_en = 1'($urandom);
      status_rd = ($urandom_range(0, 63) == 0);
      pal_wr = ($urandom_range(0, 7) == 0);
      pal_addr = 5'($urandom); pal_wdata = 8'($urandom);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ppu_pixel_output.md
Name: ppu_pixel_output

Overview:
Final stage of the PPU pipeline.
- Runs the NES dot/scanline timing (341 dots x 262 lines).
- Resolves background/sprite priority and looks up the 32-entry palette RAM.
- Emits registered ppu_pixel/ppu_x/ppu_y to the VGA frame-buffer writer, which stores a pixel only when x<256 and y<240.
- Also generates vblank, NMI and sprite-0 hit for the PPU status register.

Parameters:
DOTS_PER_LINE, 341, dots per scanline (0..340)
LINES_PER_FRAME, 262, scanlines per frame (0..261)
VBLANK_LINE, 241, line on which vblank sets
PRERENDER_LINE, 261, pre-render line; vblank and sprite-0 hit clear here

Ports:
ppu_clk  in  1  PPU dot clock
reset  in  1  synchronous, active-high
bg_en  in  1  PPUMASK background enable
spr_en  in  1  PPUMASK sprite enable
show_bg_left  in  1  show background in x 0..7
show_spr_left  in  1  show sprites in x 0..7
grayscale  in  1  PPUMASK grayscale
nmi_en  in  1  PPUCTRL NMI enable
status_rd  in  1  one-cycle pulse: CPU read of PPUSTATUS
bg_pixel  in  4  {palette[1:0], index[1:0]} for the current dot
spr_pixel  in  4  {palette[1:0], index[1:0]} of highest-priority sprite
spr_behind  in  1  sprite priority bit (1 = behind background)
spr_zero  in  1  spr_pixel comes from OAM sprite 0
pal_wr  in  1  palette write strobe
pal_addr  in  5  palette address (CPU $3F00-$3F1F, low 5 bits)
pal_wdata  in  8  write data; only [5:0] stored
pal_rdata  out  8  {2'b00, entry[pal_addr]}, combinational
ppu_pixel  out  8  {2'b00, colour index[5:0]}
ppu_x  out  9  output column 0..255; 9'h1FF when not visible
ppu_y  out  9  output line 0..239; 9'h1FF when not visible
vblank  out  1  vblank status flag
nmi  out  1  vblank & nmi_en, level
spr0_hit  out  1  sprite-0 hit flag
odd_frame  out  1  frame parity

Behaviour:
Reset:
- Counters: dot=0, line=0.
- Outputs: ppu_pixel=0, ppu_x=ppu_y=9'h1FF, vblank=0, spr0_hit=0, odd_frame=0.
- Palette RAM is not cleared.

Counters:
- dot increments every ppu_clk; at 340 it wraps to 0 and line increments.
- line wraps 261->0; odd_frame toggles at that wrap.
- Odd-frame skip: if (bg_en|spr_en) and odd_frame, then at line 261 dot 339 the next state is line 0 dot 0 (dot 340 skipped). The wrap and the odd_frame toggle still occur.

Visible region: line 0..239 and dot 1..256; x = dot-1.

Output latency: exactly one cycle.
- Inputs sampled at (line, dot) appear on ppu_pixel/ppu_x/ppu_y at the next edge.
- Outside the visible region ppu_x=ppu_y=9'h1FF, so downstream write-enable drops.

Opacity and clipping:
- bg opaque = bg_pixel[1:0]!=0 and bg_en and (x>=8 or show_bg_left).
- spr opaque = spr_pixel[1:0]!=0 and spr_en and (x>=8 or show_spr_left).

Palette address:
- Neither opaque: 5'h00.
- Sprite only, or both opaque with spr_behind=0: {1,spr_pixel}.
- Otherwise: {0,bg_pixel}.
- Rendering disabled (bg_en=spr_en=0): 5'h00.

Palette mirroring:
- Addresses 5'h10/14/18/1C alias 5'h00/04/08/0C.
- Applies to render reads, CPU writes and CPU reads.

Colour output: colour = entry[5:0]; grayscale forces colour &= 6'h30.

Palette RAM port behaviour:
- Palette write takes effect at the edge.
- A render read of the same address in the same cycle returns the old value.
- pal_rdata reflects the new value after the edge.

Sprite-0 hit:
- Sets when spr_zero and both pixels opaque (as defined above) in the visible region with x!=255.
- Sticky; clears at line 261 dot 1.

vblank:
- Sets at line VBLANK_LINE dot 1.
- Clears at line 261 dot 1, or in the cycle after status_rd.
- status_rd in the same cycle as the set condition suppresses the set for that frame.
- status_rd does not affect spr0_hit.

nmi: combinational vblank & nmi_en. Toggling nmi_en while vblank=1 raises nmi immediately.

Optional Feature:
PPU_LEFT_CLIP_EN.
- Defined: show_bg_left/show_spr_left gate pixels at x 0..7 as specified.
- Undefined: both inputs are ignored and treated as 1; the clipping comparators are removed.

Test Plan:
1. Reset 5 cycles, bg_en=spr_en=0 -> outputs 0/1FF; after 341*262 cycles line/dot return to 0, odd_frame=1.
2. Write pal[0]=0x0F, pal[0x05]=0x16; bg_en=1, bg_pixel=4'h5 at line 0 dot 1 -> next cycle ppu_pixel=0x16, ppu_x=0, ppu_y=0; bg_pixel=4'h4 -> 0x0F.
3. Write pal[0x10]=0x21 -> pal_rdata at addr 0x00 reads 0x21; grayscale=1 with colour 0x16 -> ppu_pixel=0x10.
4. bg 4'h1 and spr 4'h2 opaque with spr_behind=1 -> bg colour; spr_behind=0 -> pal[0x12]; spr_zero=1 at x=100 -> spr0_hit=1; at x=255 only -> stays 0.
5. nmi_en=1 -> vblank and nmi rise at line 241 dot 1; status_rd at line 241 dot 5 -> vblank=0 next cycle; status_rd exactly at line 241 dot 1 -> vblank never sets.
6. bg_en=1 over two frames -> odd frame is 89341 cycles, even frame is 89342; bg at x=3 with show_bg_left=0 -> backdrop (macro defined), bg colour (macro undefined).
